stdout_fifo: RTL and testbench

- Buffered console-output peripheral on the CPU data bus (addr/size/valid/write/wdata/rdata/ready).
- Sits directly upstream of the tty_tx byte serializer.
- CPU byte writes to the DATA register are queued in a FIFO and drained to tty_tx one byte at a time, so the core only stalls when the FIFO is full, not for every byte.
- Also exposes a STATUS register and a flush control.

---
 rtl/stdout_fifo_if.sv | 14 +
 rtl/stdout_fifo.sv | 92 +++++++++
 tb/tb_stdout_fifo.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stdout_fifo_if.sv
// CPU data-bus bundle between the core (master) and the buffered console
// output peripheral (slave).
interface stdout_fifo_if;
  logic [31:0] addr;
  logic [2:0]  size;
  logic        valid;
  logic        write;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output addr, size, valid, write, wdata, input rdata, ready);
  modport slave  (input addr, size, valid, write, wdata, output rdata, ready);
endinterface

// File: rtl/stdout_fifo.sv
// Buffered console output: CPU byte writes to DATA are queued and handed to
// the tty_tx serializer one byte at a time; STATUS/CTRL exposes level and flush.
module stdout_fifo #(
  parameter int          DEPTH = 16,
  parameter int          AW    = 4,
  parameter logic [31:0] BASE  = 32'h3000
) (
  input  logic               clk,
  input  logic               rstb,
  stdout_fifo_if.slave       bus,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic [AW:0]        level
);

  localparam logic [AW:0]   FULL_C  = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ready;
  logic [31:0]   r_rdata;

  logic        w_sel_data, w_sel_stat, w_full, w_empty, w_can_go;
  logic        w_accept, w_push, w_pop, w_flush;
  logic [31:0] w_status;
  logic        w_unused;

  assign w_sel_data = (bus.addr == BASE);
  assign w_sel_stat = (bus.addr == BASE + 32'd8);
  assign w_full     = (r_count == FULL_C);
  assign w_empty    = (r_count == '0);

  // Only a DATA write can be refused; reads and STATUS accesses always go.
  assign w_can_go = w_sel_stat || !(bus.write && w_full);
  assign w_accept = bus.valid && (w_sel_data || w_sel_stat) && !r_ready && w_can_go;
  assign w_push   = w_accept && w_sel_data && bus.write;
  assign w_flush  = w_accept && w_sel_stat && bus.write && bus.wdata[0];
  assign w_pop    = tx_valid && tx_ready;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_status        = '0;
    w_status[AW:0]  = r_count;
    w_status[16]    = w_empty;
    w_status[17]    = w_full;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_ready <= w_accept;
      r_rdata <= (w_accept && w_sel_stat && !bus.write) ? w_status : 32'd0;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; its contents are unobservable until written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.wdata[7:0];
  end

  assign tx_valid  = !w_empty;
  assign tx_data   = r_mem[r_rd_ptr];
  assign level     = r_count;
  assign bus.ready = r_ready;
  assign bus.rdata = r_rdata;

  assign w_unused = ^{bus.size, bus.wdata[31:8]};

endmodule

// File: tb/tb_stdout_fifo.sv
// Directed bench for stdout_fifo: bus accesses, full stall, streaming across
// pointer wrap, flush and mid-transfer reset.
module tb_stdout_fifo;

  localparam logic [31:0] BASE = 32'h3000;
  localparam logic [31:0] STAT = 32'h3008;

  logic       clk;
  logic       rstb;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [4:0] level;

  stdout_fifo_if bus_if ();

  stdout_fifo #(.DEPTH(16), .AW(4), .BASE(BASE)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .bus      (bus_if.slave),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic       mon_en = 1'b0;
  logic [7:0] got [$];
  logic [4:0] max_level = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_valid) got.push_back(tx_data);
      if (level > max_level) max_level = level;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge; holds valid until ready or max_cyc cycles, then idles one cycle.
  task automatic do_access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           input int max_cyc, output logic got_rdy, output int cyc,
                           output logic [31:0] rd);
    bus_if.addr  = a;
    bus_if.write = we;
    bus_if.wdata = wd;
    bus_if.size  = 3'd0;
    bus_if.valid = 1'b1;
    got_rdy = 1'b0;
    cyc     = 0;
    rd      = '0;
    while (cyc < max_cyc && !got_rdy) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (bus_if.ready) begin
        got_rdy = 1'b1;
        rd      = bus_if.rdata;
      end
    end
    bus_if.valid = 1'b0;
    bus_if.write = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_byte(input string tag, input logic [7:0] b);
    logic        r;
    int          c;
    logic [31:0] d;
    do_access(BASE, 1'b1, {24'hABCDEF, b}, 8, r, c, d);
    chk({tag, "_ack"}, {31'd0, r}, 32'd1);
    chk({tag, "_lat"}, c, 32'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    tx_ready = 1'b1;
    while (level != 0 && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    tx_ready = 1'b0;
    chk({tag, "_drained"}, {27'd0, level}, 32'd0);
  endtask

  logic        r_ok;
  int          cyc;
  logic [31:0] rd;

  initial begin
    bus_if.addr  = '0;
    bus_if.size  = '0;
    bus_if.valid = 1'b0;
    bus_if.write = 1'b0;
    bus_if.wdata = '0;
    tx_ready     = 1'b0;
    rstb         = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready",    {31'd0, bus_if.ready}, 32'd0);
    chk("rst_rdata",    bus_if.rdata,          32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid},     32'd0);
    chk("rst_level",    {27'd0, level},        32'd0);
    rstb = 1'b1;
    @(negedge clk);

    // STATUS after reset: empty, count 0; ack one cycle after request.
    do_access(STAT, 1'b0, 32'd0, 8, r_ok, cyc, rd);
    chk("stat0_ack",   {31'd0, r_ok}, 32'd1);
    chk("stat0_lat",   cyc,           32'd1);
    chk("stat0_rdata", rd,            32'h0001_0000);
    chk("stat0_pulse", {31'd0, bus_if.ready}, 32'd0);
    chk("stat0_rd0",   bus_if.rdata,  32'd0);
    chk("stat0_txv",   {31'd0, tx_valid}, 32'd0);

    // Two bytes, no drain; head falls through.
    wr_byte("w48", 8'h48);
    wr_byte("w69", 8'h69);
    chk("hi_level",   {27'd0, level},    32'd2);
    chk("hi_txv",     {31'd0, tx_valid}, 32'd1);
    chk("hi_head",    {24'd0, tx_data},  32'h48);
    tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_ready = 1'b0;
    chk("hi_pop_head",  {24'd0, tx_data}, 32'h69);
    chk("hi_pop_level", {27'd0, level},   32'd1);
    do_access(BASE, 1'b0, 32'd0, 8, r_ok, cyc, rd);
    chk("data_rd_ack",   {31'd0, r_ok}, 32'd1);
    chk("data_rd_rdata", rd,            32'd0);
    drain("hi");

    // Fill to DEPTH, then the 17th write stalls until a pop frees a slot.
    for (int i = 0; i < 16; i++) wr_byte($sformatf("fill%0d", i), 8'hA0 + 8'(i));
    chk("full_level", {27'd0, level}, 32'd16);
    do_access(STAT, 1'b0, 32'd0, 8, r_ok, cyc, rd);
    chk("full_stat", rd, 32'h0002_0010);
    bus_if.addr  = BASE;
    bus_if.write = 1'b1;
    bus_if.wdata = 32'h0000_00B0;
    bus_if.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("stall%0d_ready", i), {31'd0, bus_if.ready}, 32'd0);
    end
    tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_ready = 1'b0;
    chk("popfull_ready", {31'd0, bus_if.ready}, 32'd0);
    chk("popfull_level", {27'd0, level},        32'd15);
    chk("popfull_head",  {24'd0, tx_data},      32'hA1);
    @(posedge clk);
    @(negedge clk);
    chk("w17_ready", {31'd0, bus_if.ready}, 32'd1);
    chk("w17_level", {27'd0, level},        32'd16);
    bus_if.valid = 1'b0;
    bus_if.write = 1'b0;
    @(negedge clk);
    drain("full");

    // Streaming with the serializer always ready; order must survive pointer wrap.
    tx_ready  = 1'b1;
    max_level = '0;
    got.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 40; i++) wr_byte($sformatf("s%0d", i), 8'(i * 7 + 3));
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    tx_ready = 1'b0;
    chk("stream_count", got.size(), 32'd40);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] e;
      e = 8'(i * 7 + 3);
      chk($sformatf("stream_b%0d", i), {24'd0, (i < got.size()) ? got[i] : 8'hXX}, {24'd0, e});
    end
    chk("stream_maxlvl", {27'd0, max_level}, 32'd1);

    // Flush coincident with a pop: queue emptied, the pop is dropped.
    for (int i = 0; i < 5; i++) wr_byte($sformatf("q%0d", i), 8'h30 + 8'(i));
    chk("q_level", {27'd0, level}, 32'd5);
    bus_if.addr  = STAT;
    bus_if.write = 1'b1;
    bus_if.wdata = 32'd1;
    bus_if.valid = 1'b1;
    tx_ready     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.valid = 1'b0;
    bus_if.write = 1'b0;
    chk("flush_ready", {31'd0, bus_if.ready}, 32'd1);
    chk("flush_level", {27'd0, level},        32'd0);
    chk("flush_txv",   {31'd0, tx_valid},     32'd0);
    repeat (4) @(negedge clk);
    chk("flush_quiet_txv", {31'd0, tx_valid}, 32'd0);
    chk("flush_quiet_lvl", {27'd0, level},    32'd0);
    tx_ready = 1'b0;

    // Write of 0 to CTRL does nothing.
    wr_byte("k0", 8'h55);
    do_access(STAT, 1'b1, 32'd0, 8, r_ok, cyc, rd);
    chk("noflush_level", {27'd0, level},   32'd1);
    chk("noflush_head",  {24'd0, tx_data}, 32'h55);
    wr_byte("k1", 8'h56);
    wr_byte("k2", 8'h57);

    // Async reset mid-transfer discards the queue immediately.
    chk("prerst_level", {27'd0, level}, 32'd3);
    rstb = 1'b0;
    #1;
    chk("arst_level", {27'd0, level},        32'd0);
    chk("arst_txv",   {31'd0, tx_valid},     32'd0);
    chk("arst_ready", {31'd0, bus_if.ready}, 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);

    // Unmapped address: never acknowledged, no state change.
    do_access(32'h3004, 1'b0, 32'd0, 4, r_ok, cyc, rd);
    chk("unmap_rd_ack", {31'd0, r_ok}, 32'd0);
    chk("unmap_rd_rd",  bus_if.rdata,  32'd0);
    do_access(32'h3004, 1'b1, 32'h77, 4, r_ok, cyc, rd);
    chk("unmap_wr_ack", {31'd0, r_ok},     32'd0);
    chk("unmap_level",  {27'd0, level},    32'd0);
    chk("unmap_txv",    {31'd0, tx_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
